pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Parametrised program-counter sequencer for the basic processor; successor to the single-width PC block.
- Adds configurable PC/offset widths, a configurable halt address, a stall input, and a call/return stack (RAS) so subroutines need no register save.
- Sits between the decoder's control outputs and the instruction ROM address input.

Parameters:
PC_W, 10, PC width in bits
OFF_W, 7, signed relative-offset width; must be <= PC_W
HALT_ADDR, 63, halt asserts once PC > HALT_ADDR
BR_SKIP, 2, increment applied on branch_en (skips the following jump)
RAS_DEPTH, 4, return-address stack entries; power of two, >= 2

Ports:
CLK  in  1  clock, rising edge
init  in  1  synchronous active-high reset
stall  in  1  hold PC and RAS this cycle
jump_en  in  1  relative jump by counter
branch_en  in  1  PC += BR_SKIP
call_en  in  1  push PC+1, then relative jump by counter
ret_en  in  1  pop return address into PC
counter  in  OFF_W  signed two's-complement offset
halt  out  1  sticky program-halted flag
PC  out  PC_W  current instruction address
ras_ovf  out  1  sticky: push onto a full RAS
ras_unf  out  1  sticky: pop from an empty RAS

Behaviour:
- All state updates on posedge CLK. init has top priority: PC=0, halt=0, ras_ovf=0, ras_unf=0, RAS count=0. RAS entry contents are don't-care after init.
- init mid-operation discards the stack and any pending flags in the same cycle.
- Per-cycle priority, evaluated only when init=0:
  1. If halt=1: hold everything.
  2. Else if PC > HALT_ADDR: halt<=1, PC held.
  3. Else if stall=1: hold.
  4. Else if ret_en=1: RAS not empty gives PC<=top and count--. RAS empty gives ras_unf<=1, halt<=1, PC held.
  5. Else if call_en=1: push PC+1 and PC<=PC+sext(counter).
  6. Else if jump_en=1: PC<=PC+sext(counter).
  7. Else if branch_en=1: PC<=PC+BR_SKIP.
  8. Else: PC<=PC+1.
- Arithmetic: counter is sign-extended to PC_W. All adds are modulo 2^PC_W, so wrap below 0 or above 2^PC_W-1 is silent.
- Offset 0 on jump or call gives PC unchanged, which is a legal self-loop.
- RAS is circular with a top pointer and a 0..RAS_DEPTH count.
  - Push when full: overwrite the oldest entry, count stays RAS_DEPTH, ras_ovf<=1.
  - Pushed value is PC+1 modulo 2^PC_W.
- Halt latency: the first cycle with PC > HALT_ADDR leaves PC unchanged, and halt is seen high on the next cycle.
- halt, ras_ovf and ras_unf are cleared only by init.
- Simultaneous enables resolve strictly by the priority above. Lower-priority enables are ignored, with no side effect on the RAS.
- Outputs are registered only, with no combinational path from the inputs.

Optional Feature:
- Macro PC_SEQ_BRK_EN.
- Defined: adds ports brk_we (in, 1) and brk_addr (in, PC_W).
  - brk_we=1 loads the breakpoint register and sets it valid; init clears valid.
  - When valid, PC==brk, halt=0 and stall=0: halt<=1 and PC held. This check sits between priority steps 2 and 3.
- Undefined: no ports and no logic; behaviour exactly as above.

Decomposition:
- Package pc_seq_pkg holds typedef pc_t (logic [PC_W-1:0]), typedef off_t (signed [OFF_W-1:0]), and a sext_off() function.
- One sub-module, pc_seq_ras. Ports: CLK, init, push, pop, din, dout, empty, full.
  - Circular buffer with top pointer and count.
  - Push on full overwrites the oldest entry.
- The top-level owns priority, PC arithmetic and the sticky flags.

Test Plan:
- Reset then free-run: init 1 cycle, all enables 0. PC goes 0,1,2,...,64. PC=64 holds one cycle, then halt=1 and PC stays 64 indefinitely.
- Jumps: at PC=10, jump_en with counter=7'h7D (-3) gives PC=7. Then counter=7'h05 gives PC=12. At PC=1, counter=-3 gives PC=1022 (wrap); with HALT_ADDR=63 this causes halt on the following cycle.
- Call/return: PC=5, call_en, counter=+20 gives PC=25 and RAS count 1. Increment to 27, then ret_en gives PC=6. A second ret_en gives ras_unf=1, halt=1 and PC held at 6.
- Overflow: 5 nested calls of +1 from PC=0 give ras_ovf=1. Four returns then yield the 4 newest return addresses in LIFO order; a 5th return raises ras_unf.
- Priority and stall: stall with jump_en gives PC held. call_en with jump_en gives call only. ret_en with branch_en gives ret only. branch_en alone at PC=3 gives PC=5. init asserted mid-call-chain clears PC, count and flags in 1 cycle.
- PC_SEQ_BRK_EN: brk_addr=9 loaded and free-run from 0. PC reaches 9, then halt=1 on the next cycle with PC=9. Without the macro, the same stimulus (minus the brk ports) runs to 64.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: default widths, PC and offset types,
// and the offset sign-extension helper.
package pc_seq_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int OFF_W_DEF = 7;

    typedef logic [PC_W_DEF-1:0]         pc_t;
    typedef logic signed [OFF_W_DEF-1:0] off_t;

    // A size cast of a signed operand replicates its sign bit.
    function automatic pc_t sext_off(input off_t off);
        return pc_t'(off);
    endfunction

endpackage

// File: rtl/pc_seq_ras.sv
// Return-address stack: circular buffer with a top pointer and an occupancy count.
// A push while full overwrites the oldest entry and leaves the count at DEPTH.
module pc_seq_ras
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PC_W_DEF
) (
    input  logic         CLK,
    input  logic         init,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] top;
    logic [PW-1:0] top_inc;
    logic [CW-1:0] count;

    assign top_inc = top + 1'b1;
    assign dout    = mem[top];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    always_ff @(posedge CLK) begin
        if (init) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            top   <= top_inc;
            count <= full ? count : count + 1'b1;
        end else if (pop && !empty) begin
            top   <= top - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Entry storage needs no reset; stale contents are unreachable once count is 0.
    always_ff @(posedge CLK) begin
        if (!init && push) begin
            mem[top_inc] <= din;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: prioritised jump/branch/call/return with a return-address
// stack and sticky halt/overflow/underflow flags. Define PC_SEQ_BRK_EN for a breakpoint.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int OFF_W     = OFF_W_DEF,
    parameter int HALT_ADDR = 63,
    parameter int BR_SKIP   = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             init,
    input  logic             stall,
    input  logic             jump_en,
    input  logic             branch_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [OFF_W-1:0] counter,
`ifdef PC_SEQ_BRK_EN
    input  logic             brk_we,
    input  logic [PC_W-1:0]  brk_addr,
`endif
    output logic             halt,
    output logic [PC_W-1:0]  PC,
    output logic             ras_ovf,
    output logic             ras_unf
);

    localparam logic [PC_W-1:0] HALT_PC = PC_W'(HALT_ADDR);
    localparam logic [PC_W-1:0] BR_INC  = PC_W'(BR_SKIP);

    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] pc_nxt;
    logic            halt_nxt;
    logic            ovf_nxt;
    logic            unf_nxt;
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_dout;
    logic            ras_empty;
    logic            ras_full;
    logic            brk_hit;

    assign offset = PC_W'(signed'(counter));

`ifdef PC_SEQ_BRK_EN
    logic [PC_W-1:0] brk;
    logic            brk_vld;

    always_ff @(posedge CLK) begin
        if (init) begin
            brk_vld <= 1'b0;
        end else if (brk_we) begin
            brk     <= brk_addr;
            brk_vld <= 1'b1;
        end
    end

    assign brk_hit = brk_vld && (PC == brk);
`else
    assign brk_hit = 1'b0;
`endif

    always_comb begin
        pc_nxt   = PC;
        halt_nxt = halt;
        ovf_nxt  = ras_ovf;
        unf_nxt  = ras_unf;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (!halt) begin
            if (PC > HALT_PC) begin
                halt_nxt = 1'b1;
            end else if (brk_hit && !stall) begin
                halt_nxt = 1'b1;
            end else if (!stall) begin
                if (ret_en) begin
                    if (ras_empty) begin
                        unf_nxt  = 1'b1;
                        halt_nxt = 1'b1;
                    end else begin
                        pc_nxt  = ras_dout;
                        ras_pop = 1'b1;
                    end
                end else if (call_en) begin
                    ras_push = 1'b1;
                    ovf_nxt  = ras_ovf | ras_full;
                    pc_nxt   = PC + offset;
                end else if (jump_en) begin
                    pc_nxt = PC + offset;
                end else if (branch_en) begin
                    pc_nxt = PC + BR_INC;
                end else begin
                    pc_nxt = PC + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (init) begin
            PC      <= '0;
            halt    <= 1'b0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            PC      <= pc_nxt;
            halt    <= halt_nxt;
            ras_ovf <= ovf_nxt;
            ras_unf <= unf_nxt;
        end
    end

    pc_seq_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .CLK   (CLK),
        .init  (init),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (PC + 1'b1),
        .dout  (ras_dout),
        .empty (ras_empty),
        .full  (ras_full)
    );

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed scenarios plus random traffic against a queue-based
// reference model; expected states are queued per cycle and checked by a monitor.
module tb_pc_seq;

    localparam int PC_W      = 10;
    localparam int PC_MOD    = 1 << PC_W;
    localparam int HALT_ADDR = 63;
    localparam int BR_SKIP   = 2;
    localparam int RAS_DEPTH = 4;

    typedef struct {
        int pc;
        bit halt;
        bit ovf;
        bit unf;
    } exp_t;

    logic        CLK = 1'b0;
    logic        init = 1'b0, stall = 1'b0, jump_en = 1'b0, branch_en = 1'b0;
    logic        call_en = 1'b0, ret_en = 1'b0;
    logic [6:0]  counter = '0;
    logic        halt, ras_ovf, ras_unf;
    logic [9:0]  PC;
`ifdef PC_SEQ_BRK_EN
    logic        brk_we = 1'b0;
    logic [9:0]  brk_addr = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // reference model state
    int m_pc = 0;
    bit m_halt = 0, m_ovf = 0, m_unf = 0;
    int stk[$];
    bit m_bv = 0;
    int m_brk = 0;

    always #5 CLK = ~CLK;

    pc_seq #(
        .PC_W(PC_W), .OFF_W(7), .HALT_ADDR(HALT_ADDR), .BR_SKIP(BR_SKIP), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .CLK(CLK), .init(init), .stall(stall), .jump_en(jump_en), .branch_en(branch_en),
        .call_en(call_en), .ret_en(ret_en), .counter(counter),
`ifdef PC_SEQ_BRK_EN
        .brk_we(brk_we), .brk_addr(brk_addr),
`endif
        .halt(halt), .PC(PC), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    function automatic void model(input bit i, s, j, b, c, r, input logic [6:0] cnt,
                                  input bit bwe, input int ba);
        int off;
        off = int'($signed(cnt));
        if (i) begin
            m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0; m_bv = 0;
            stk.delete();
            return;
        end
        if (m_halt) begin
        end else if (m_pc > HALT_ADDR) begin
            m_halt = 1;
        end else if (m_bv && m_pc == m_brk && !s) begin
            m_halt = 1;
        end else if (s) begin
        end else if (r) begin
            if (stk.size() > 0) m_pc = stk.pop_back();
            else begin m_unf = 1; m_halt = 1; end
        end else if (c) begin
            if (stk.size() == RAS_DEPTH) begin void'(stk.pop_front()); m_ovf = 1; end
            stk.push_back((m_pc + 1) % PC_MOD);
            m_pc = (m_pc + off + PC_MOD) % PC_MOD;
        end else if (j) begin
            m_pc = (m_pc + off + PC_MOD) % PC_MOD;
        end else if (b) begin
            m_pc = (m_pc + BR_SKIP) % PC_MOD;
        end else begin
            m_pc = (m_pc + 1) % PC_MOD;
        end
        if (bwe) begin m_brk = ba; m_bv = 1; end
    endfunction

    // Drive one cycle at the falling edge, queue the model's prediction, return after the
    // rising edge once the monitor has sampled.
    task automatic step(input bit i, s, j, b, c, r, input logic [6:0] cnt,
                        input bit bwe = 0, input int ba = 0);
        exp_t e;
        bit   we_eff;
        @(negedge CLK);
        init = i; stall = s; jump_en = j; branch_en = b; call_en = c; ret_en = r; counter = cnt;
`ifdef PC_SEQ_BRK_EN
        brk_we = bwe; brk_addr = 10'(ba);
        we_eff = bwe;
`else
        we_eff = 0;
`endif
        model(i, s, j, b, c, r, cnt, we_eff, ba);
        e.pc = m_pc; e.halt = m_halt; e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 7'h00);
    endtask

    task automatic chk(input string nm, input int pc, input bit h, input bit o, input bit u);
        n_checks++;
        if (int'(PC) != pc || halt !== h || ras_ovf !== o || ras_unf !== u) begin
            n_fail++;
            $display("FAIL %s: got PC=%0d halt=%0b ovf=%0b unf=%0b, expected PC=%0d halt=%0b ovf=%0b unf=%0b",
                     nm, PC, halt, ras_ovf, ras_unf, pc, h, o, u);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (int'(PC) != e.pc || halt !== e.halt || ras_ovf !== e.ovf || ras_unf !== e.unf) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got PC=%0d halt=%0b ovf=%0b unf=%0b, model PC=%0d halt=%0b ovf=%0b unf=%0b",
                             $time, PC, halt, ras_ovf, ras_unf, e.pc, e.halt, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit i, s, j, b, c, r, bwe;
        int o;

        // reset and free-run to halt
        step(1, 0, 0, 0, 0, 0, 7'h00);
        chk("reset", 0, 0, 0, 0);
        idle(64);
        chk("freerun_pc64", 64, 0, 0, 0);
        idle(1);
        chk("halt_latency", 64, 1, 0, 0);
        idle(3);
        chk("halt_sticky", 64, 1, 0, 0);

        // relative jumps and wrap
        step(1, 0, 0, 0, 0, 0, 7'h00);
        idle(10);
        step(0, 0, 1, 0, 0, 0, 7'h7D);
        chk("jump_minus3", 7, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 7'h05);
        chk("jump_plus5", 12, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 7'h00);
        chk("jump_self", 12, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 7'h00);
        idle(1);
        step(0, 0, 1, 0, 0, 0, 7'h7D);
        chk("jump_wrap", 1022, 0, 0, 0);
        idle(1);
        chk("wrap_halt", 1022, 1, 0, 0);

        // call / return / underflow
        step(1, 0, 0, 0, 0, 0, 7'h00);
        idle(5);
        step(0, 0, 0, 0, 1, 0, 7'd20);
        chk("call_plus20", 25, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 7'h00);
        chk("ret_to_6", 6, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 7'h00);
        chk("ret_underflow", 6, 1, 0, 1);

        // overflow: five nested calls, then LIFO of the four newest
        step(1, 0, 0, 0, 0, 0, 7'h00);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 0, 7'd1);
        chk("ras_overflow", 5, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 1, 7'h00);
            chk("ras_lifo", 5 - k, 0, 1, 0);
        end
        step(0, 0, 0, 0, 0, 1, 7'h00);
        chk("ras_fifth_ret", 2, 1, 1, 1);

        // priority and stall
        step(1, 0, 0, 0, 0, 0, 7'h00);
        idle(3);
        step(0, 1, 1, 0, 0, 0, 7'd5);
        chk("stall_jump", 3, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 7'h00);
        chk("branch", 5, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 7'd4);
        chk("call_over_jump", 9, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 7'h00);
        chk("ret_over_branch", 6, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 7'd2);
        step(0, 0, 0, 0, 1, 0, 7'd2);
        step(1, 0, 0, 0, 1, 0, 7'd2);
        chk("init_mid_chain", 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 7'h00);
        chk("stack_cleared", 0, 1, 0, 1);

        // breakpoint at 9 (runs on to 64 when the breakpoint is not built)
        step(1, 0, 0, 0, 0, 0, 7'h00);
        step(0, 0, 0, 0, 0, 0, 7'h00, 1, 9);
        idle(8);
        chk("brk_reach9", 9, 0, 0, 0);
        idle(1);
`ifdef PC_SEQ_BRK_EN
        chk("brk_halt", 9, 1, 0, 0);
`else
        chk("no_brk_pass9", 10, 0, 0, 0);
`endif
        idle(55);
`ifdef PC_SEQ_BRK_EN
        chk("brk_final", 9, 1, 0, 0);
`else
        chk("no_brk_final", 64, 1, 0, 0);
`endif

        // random traffic against the model
        step(1, 0, 0, 0, 0, 0, 7'h00);
        for (int k = 0; k < 600; k++) begin
            i = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 7) == 0);
            j = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            bwe = ($urandom_range(0, 31) == 0);
            o = int'($urandom_range(0, 16)) - 8;
            step(i, s, j, b, c, r, 7'(o), bwe, int'($urandom_range(0, 40)));
        end

        @(posedge CLK);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
